// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the ALU (req0) and load data (req1).
// Optional grant locking is compiled in with `define WB_ARB_LOCK_EN.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit DISCARD_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
`ifdef WB_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic              prio;
  logic              accept;
  logic              m0, m1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

`ifdef WB_ARB_LOCK_EN
  logic locked, lock_id, win_lock;
  // While locked to one requester the other is invisible to the arbiter.
  assign m0       = req0 & ~(locked &  lock_id);
  assign m1       = req1 & ~(locked & ~lock_id);
  assign win_lock = gnt0 ? lock0 : lock1;
`else
  assign m0 = req0;
  assign m1 = req1;
`endif

  assign accept   = (state == EMPTY) | rf_ready;
  assign gnt0     = ~rst & accept & m0 & (~m1 | ~prio);
  assign gnt1     = ~rst & accept & m1 & (~m0 |  prio);
  assign win_addr = gnt0 ? addr0 : addr1;
  assign win_data = gnt0 ? data0 : data1;
  assign rf_we    = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      rf_waddr <= '0;
      rf_wdata <= '0;
      sel      <= 1'b0;
      prio     <= 1'b0;
`ifdef WB_ARB_LOCK_EN
      locked   <= 1'b0;
      lock_id  <= 1'b0;
`endif
    end else if (accept) begin
      if (gnt0 | gnt1) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        sel      <= gnt0;
        // Writes to r0 complete the handshake but leave the stage empty.
        state    <= (DISCARD_R0 && (win_addr == '0)) ? EMPTY : FULL;
        prio     <= gnt0;
`ifdef WB_ARB_LOCK_EN
        if (win_lock) begin
          locked  <= 1'b1;
          lock_id <= gnt1;
          prio    <= gnt1;
        end else begin
          locked  <= 1'b0;
        end
`endif
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: the stimulus pushes expected writes, a monitor pops them on consumption.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, rf_ready = 1'b0;
  logic [4:0]  addr0 = '0, addr1 = '0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, rf_we, sel;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_ARB_LOCK_EN
  logic        lock0 = 1'b0, lock1 = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        sel;
  } wr_t;
  wr_t exp_q[$];

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DISCARD_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
`ifdef WB_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check grants, record expected writes, return at posedge.
  task automatic cyc(input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic r1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic rdy, input logic e0, input logic e1);
    @(negedge clk);
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
    rf_ready = rdy;
    #1;
    chk("gnt0", {31'b0, gnt0}, {31'b0, e0});
    chk("gnt1", {31'b0, gnt1}, {31'b0, e1});
    if (e0 && a0 != 5'd0) exp_q.push_back('{a0, d0, 1'b1});
    if (e1 && a1 != 5'd0) exp_q.push_back('{a1, d1, 1'b0});
    @(posedge clk);
  endtask

  // Monitor: a write is consumed when rf_we and rf_ready are both high before the edge.
  initial begin
    logic pend0, pend1;
    wr_t  e;
    pend0 = 1'b0; pend1 = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (pend0 && !req0) begin
        tests++; fails++;
        $display("FAIL proto_req0: dropped before grant");
      end
      if (pend1 && !req1) begin
        tests++; fails++;
        $display("FAIL proto_req1: dropped before grant");
      end
      pend0 = !rst && req0 && !gnt0;
      pend1 = !rst && req1 && !gnt1;
      if (rf_we === 1'b1 && rf_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {27'b0, rf_waddr}, {27'b0, e.addr});
          chk("wr_data", rf_wdata, e.data);
          chk("wr_sel",  {31'b0, sel}, {31'b0, e.sel});
        end
      end
    end
  end

  initial begin
    // Reset with both requesting: no grants, cleared outputs.
    rst = 1'b1;
    cyc(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 0, 0);
    cyc(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 0, 0);
    #1;
    chk("rst_we",    {31'b0, rf_we}, 32'h0);
    chk("rst_waddr", {27'b0, rf_waddr}, 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_sel",   {31'b0, sel}, 32'h0);
    rst = 1'b0;

    // Single request, then a req1-only grant to bring prio back to 0.
    cyc(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 1, 0);
    #1;
    chk("lat_we",    {31'b0, rf_we}, 32'h1);
    chk("lat_waddr", {27'b0, rf_waddr}, 32'h3);
    chk("lat_wdata", rf_wdata, 32'hDEADBEEF);
    cyc(0, 5'd0, 32'h0, 1, 5'd7, 32'h11, 1, 0, 1);

    // Contention: strict alternation 0,1,0,1.
    cyc(1, 5'd4, 32'hA0, 1, 5'd5, 32'hB0, 1, 1, 0);
    cyc(1, 5'd4, 32'hA1, 1, 5'd5, 32'hB0, 1, 0, 1);
    cyc(1, 5'd4, 32'hA1, 1, 5'd5, 32'hB1, 1, 1, 0);
    cyc(1, 5'd4, 32'hA2, 1, 5'd5, 32'hB1, 1, 0, 1);
    cyc(1, 5'd4, 32'hA2, 0, 5'd0, 32'h0,  1, 1, 0);

    // Stall: stage full with A2, rf_ready low for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 5'd0, 32'h0, 1, 5'd6, 32'hC0, 0, 0, 0);
      #1;
      chk("stall_we",    {31'b0, rf_we}, 32'h1);
      chk("stall_waddr", {27'b0, rf_waddr}, 32'h4);
      chk("stall_wdata", rf_wdata, 32'hA2);
      chk("stall_sel",   {31'b0, sel}, 32'h1);
    end
    cyc(0, 5'd0, 32'h0, 1, 5'd6, 32'hC0, 1, 0, 1);
    #1;
    chk("unstall_wdata", rf_wdata, 32'hC0);

    // R0 discard: prio is 1 before it, must rotate back to 0.
    cyc(1, 5'd8, 32'hE0, 0, 5'd0, 32'h0, 1, 1, 0);
    cyc(0, 5'd0, 32'h0, 1, 5'd0, 32'hD0, 1, 0, 1);
    #1;
    chk("discard_we", {31'b0, rf_we}, 32'h0);
    cyc(1, 5'd9, 32'hF0, 1, 5'd10, 32'hF1, 1, 1, 0);
    cyc(0, 5'd0, 32'h0,  1, 5'd10, 32'hF1, 1, 0, 1);

`ifdef WB_ARB_LOCK_EN
    // Locked to requester 0 for 3 beats, released on the 4th, then requester 1.
    lock0 = 1'b1;
    cyc(1, 5'd12, 32'h50, 1, 5'd11, 32'h61, 1, 1, 0);
    cyc(1, 5'd12, 32'h51, 1, 5'd11, 32'h61, 1, 1, 0);
    cyc(1, 5'd12, 32'h52, 1, 5'd11, 32'h61, 1, 1, 0);
    lock0 = 1'b0;
    cyc(1, 5'd12, 32'h53, 1, 5'd11, 32'h61, 1, 1, 0);
    cyc(0, 5'd0,  32'h0,  1, 5'd11, 32'h61, 1, 0, 1);
`endif

    // Drain.
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 0);
    #3;
    chk("drain_we", {31'b0, rf_we}, 32'h0);
    chk("drain_q",  exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Round-robin arbiter sharing the single register-file write port between two writeback sources: requester 0 (ALU result) and requester 1 (memory load data).
- Grants one requester per cycle and registers the winner's address and data into a one-entry output stage that drives the register-file write port.
- Drives the select line of the writeback 2:1 mux.
- Stalls cleanly when the register file cannot accept a write.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- DISCARD_R0, 1, when 1, writes to address 0 complete the handshake but never assert rf_we.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 write request; held with addr0/data0 stable until gnt0
- addr0  input  ADDR_W  requester 0 destination register
- data0  input  DATA_W  requester 0 write data
- gnt0  output  1  combinational grant to requester 0; handshake completes on the edge where req0 and gnt0 are both 1
- req1  input  1  requester 1 write request, same rules as req0
- addr1  input  ADDR_W  requester 1 destination register
- data1  input  DATA_W  requester 1 write data
- gnt1  output  1  combinational grant to requester 1
- rf_ready  input  1  register file consumes the current write this cycle
- rf_we  output  1  registered write enable
- rf_waddr  output  ADDR_W  registered write address
- rf_wdata  output  DATA_W  registered write data
- sel  output  1  registered mux select: 1 = stage holds requester 0 data, 0 = requester 1

Behaviour:
- Reset (rst=1 at an edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, sel=0.
  - Priority pointer prio=0 (requester 0 wins ties).
  - gnt0=gnt1=0 while rst=1.
  - rst overrides any handshake in the same cycle; a pending stage entry is discarded.
- States: EMPTY (rf_we=0) and FULL (rf_we=1).
- Acceptance: accept = (state==EMPTY) | rf_ready. With accept=0, gnt0=gnt1=0 and the outputs hold.
- Grant logic (combinational, only when accept=1):
  - Only req0 → gnt0. Only req1 → gnt1.
  - Both requesting → requester prio granted.
  - gnt0 and gnt1 are never both 1.
- On an edge with a grant to i:
  - rf_waddr=addr_i, rf_wdata=data_i, sel=(i==0).
  - prio = 1-i.
  - rf_we=1, except rf_we=0 when DISCARD_R0=1 and addr_i==0.
- On an edge with accept=1 and no grant:
  - rf_we=0 (FULL→EMPTY if rf_ready).
  - rf_waddr, rf_wdata, sel and prio unchanged.
- FULL with rf_ready=0: everything holds; requesters wait with their req asserted.
- Latency: a request granted in cycle N appears on rf_* in cycle N+1.
- Throughput: one write per cycle while rf_ready=1.
- Fairness: with both requesting continuously, grants strictly alternate.
- Discarded R0 writes still rotate prio.
- A request deasserted before grant is a protocol violation; behaviour is undefined and the bench flags it.

Optional Feature:
- Macro WB_ARB_LOCK_EN.
- Defined:
  - Adds inputs lock0 and lock1 (1 bit each), sampled with the corresponding req.
  - When a grant to i occurs with lock_i=1, the arbiter enters LOCKED(i): prio is pinned to i and the other requester is masked.
  - LOCKED(i) exits on the edge of a grant to i with lock_i=0; prio then becomes 1-i.
  - In LOCKED(i) with req_i=0, no grant is issued.
  - Reset clears LOCKED.
- Undefined: no lock ports, pure round-robin as above.

Test Plan:
- Reset: assert rst for 2 cycles with req0=req1=1 → gnt0=gnt1=0, rf_we=0, rf_waddr=0, rf_wdata=0, sel=0.
- Single request: req0=1, addr0=3, data0=0xDEADBEEF, rf_ready=1 → gnt0=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF, sel=1.
- Contention: req0 and req1 held for 4 cycles, rf_ready=1 → grant order 0,1,0,1; sel sequence 1,0,1,0.
- Stall: stage FULL, rf_ready=0 for 3 cycles with req1=1 → no grants, rf_* frozen; rf_ready=1 → gnt1 that cycle, new data next cycle.
- R0 discard: DISCARD_R0=1, req1=1, addr1=0 → gnt1=1, next cycle rf_we=0; a following req0/req1 tie grants requester 0.
- Lock (WB_ARB_LOCK_EN): req0/lock0=1 for 3 beats with req1=1 throughout → 3 consecutive gnt0; final beat with lock0=0 → next grant gnt1.
